fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Multi-cycle instruction sequencer that owns the program counter's advance and branch controls. It fetches one instruction per step over a ready/valid handshake to instruction memory, hands it to the execute stage, and waits for completion. It then issues a single PC-advance pulse, with the branch qualified by the zero flag. It sits between instruction memory, the execute datapath and the program counter, whose advance is gated by `pc_step`.

## Interface
- `INSTR_W`, 9: instruction width.
- `OPCODE_W`, 3: opcode field width, taken from `ir[INSTR_W-1 -: OPCODE_W]`.
- `BRANCH_OP`, 3'b110: opcode of the conditional branch (branch if zero).
- `HALT_INSTR`, 9'h1FF: full-word halt encoding.
- `CNT_W`, 32: width of the performance counters (only with the configuration macro).

- `clk` in 1: clock.
- `reset` in 1: reset; asynchronous, active-high.
- `start` in 1: begin execution; honoured in IDLE only.
- `imem_req` out 1: fetch request to instruction memory.
- `imem_ready` in 1: instruction memory returns data this cycle.
- `imem_rdata` in INSTR_W: fetched instruction.
- `instr_out` out INSTR_W: latched instruction register `ir`.
- `instr_valid` out 1: one-cycle pulse telling execute that `instr_out` is new.
- `exec_done` in 1: execute stage finished the current instruction.
- `zero_flag` in 1: ALU zero flag.
- `pc_step` out 1: one-cycle PC advance pulse.
- `branch_en` out 1: apply the immediate on this `pc_step`.
- `imm_out` out 8: branch offset, `{{2{ir[5]}}, ir[5:0]}`.
- `done` out 1: processor halted.
- `cycle_count` out CNT_W: active-cycle counter; macro only.
- `instr_count` out CNT_W: retired-instruction counter; macro only.

## Operation
- States: IDLE, FETCH, DECODE, EXECUTE, UPDATE, HALTED.
- **IDLE**
  - `start` → FETCH; otherwise stay.
- **FETCH**
  - `imem_req`=1 and held until `imem_ready`.
  - On `imem_ready`: `ir` ← `imem_rdata`, go to DECODE.
- **DECODE**
  - If `ir`==HALT_INSTR → HALTED, with no `instr_valid` and no `pc_step`.
  - Otherwise `instr_valid`=1 for this cycle, go to EXECUTE.
- **EXECUTE**
  - Wait for `exec_done`.
  - On `exec_done`: `taken` ← (opcode==BRANCH_OP) & `zero_flag`, sampled in that same cycle. Go to UPDATE.
- **UPDATE**
  - `pc_step`=1 and `branch_en`=`taken` for this cycle, go to FETCH.
- **HALTED**
  - `done`=1; terminal. `start` is ignored; only `reset` exits.
- Inputs are ignored outside the states named above: `start` outside IDLE, `imem_ready` outside FETCH, `exec_done` outside EXECUTE.
- All outputs are decoded from registered state and `ir`/`taken` (Moore). There is no combinational input-to-output path.

## Timing
- Reset values:
  - state=IDLE; `ir`=0; `taken`=0.
  - `imem_req`, `instr_valid`, `pc_step`, `branch_en`, `done` = 0.
  - `instr_out`=0; `imm_out`=0; counters=0.
- Minimum instruction latency is 4 cycles (FETCH, DECODE, EXECUTE, UPDATE), with `imem_ready` and `exec_done` each high on first eligible cycle.
- `start` at edge N → `imem_req` high in cycle N+1.
- `pc_step` is exactly one cycle per non-halt instruction and is never asserted in two consecutive cycles.
- `branch_en` is only ever high together with `pc_step`.
- A halt fetched at PC=k leaves the PC at k, since no step is issued.
- Reset mid-operation (any state) forces IDLE in the same instant and drops all pulses. An in-flight fetch is abandoned.

## Configuration
- Macro: `FETCH_SEQ_PERF_EN`.
- Defined:
  - `cycle_count` increments every cycle the state is not IDLE/HALTED.
  - `instr_count` increments in each UPDATE cycle and on the DECODE cycle that detects a halt.
  - Both saturate at all-ones.
- Undefined: both ports and all counter logic are absent; behaviour is otherwise identical.

## Structure
- Package `fetch_seq_pkg`:
  - state enum `fseq_state_t`.
  - default `BRANCH_OP` and `HALT_INSTR` constants.
  - `IMM_W`=8.
- Sub-module `sat_counter` (parameter width; inputs `en`, `clr`), instantiated twice under the macro.

## Test plan
- Reset, then `start`, `imem_ready`=1, `exec_done`=1 each eligible cycle, non-branch instr 9'h012 → `instr_valid` at cycle 3, `pc_step` at cycle 5, `branch_en`=0.
- Branch instr {3'b110, 6'b111110} with `zero_flag`=1 at `exec_done` → `pc_step`=1, `branch_en`=1, `imm_out`=8'hFE. The same instruction with `zero_flag`=0 → `branch_en`=0.
- `imem_ready` delayed 3 cycles → `imem_req` held 4 cycles, `ir` unchanged until ready, then the normal sequence follows.
- Fetch 9'h1FF → `done`=1 two cycles after `imem_ready`; no `pc_step`; later `start` pulses ignored; `done` stays 1 until reset.
- Assert `reset` while in EXECUTE → all outputs 0 immediately; a following `start` restarts cleanly from FETCH.
- With `FETCH_SEQ_PERF_EN`: run 3 non-halt instructions plus a halt, each 4 cycles → `instr_count`=4, `cycle_count`=14, both frozen in HALTED.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
// ============================================================================
// fetch_seq_pkg
//
// Purpose: shared types and constants for the fetch sequencer slice.
//   - fseq_state_t       : sequencer state encoding
//   - DEFAULT_BRANCH_OP  : opcode of the conditional branch (branch if zero)
//   - DEFAULT_HALT_INSTR : full-word halt encoding
//   - IMM_W              : width of the sign-extended branch offset
//   - sext_imm()         : builds the branch offset from the 6-bit field
// ============================================================================
package fetch_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_DECODE  = 3'd2,
        ST_EXECUTE = 3'd3,
        ST_UPDATE  = 3'd4,
        ST_HALTED  = 3'd5
    } fseq_state_t;

    localparam logic [2:0] DEFAULT_BRANCH_OP  = 3'b110;
    localparam logic [8:0] DEFAULT_HALT_INSTR = 9'h1FF;
    localparam int         IMM_W              = 8;

    // The branch offset field is six bits wide; bit 5 is its sign.
    function automatic logic [IMM_W-1:0] sext_imm(input logic [5:0] field);
        return {{(IMM_W-6){field[5]}}, field};
    endfunction

endpackage

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter
//
// Purpose: up-counter that sticks at all-ones instead of wrapping.
//
// Ports:
//   clk    in  : clock
//   reset  in  : asynchronous, active-high reset (count -> 0)
//   en     in  : increment this cycle
//   clr    in  : synchronous clear, dominates en
//   count  out : current count (WIDTH bits)
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// ============================================================================
// fetch_sequencer
//
// Purpose: multi-cycle instruction sequencer. Fetches one instruction over a
// ready/valid handshake, hands it to execute, waits for completion, then
// issues a single PC-advance pulse whose branch qualifier is the zero flag
// sampled when execute reports done. A full-word halt instruction parks the
// sequencer in HALTED without stepping the PC; only reset leaves HALTED.
//
// Ports:
//   clk          in  : clock
//   reset        in  : asynchronous, active-high reset
//   start        in  : begin execution (only looked at in IDLE)
//   imem_req     out : fetch request, held until imem_ready
//   imem_ready   in  : instruction memory returns data this cycle
//   imem_rdata   in  : fetched instruction
//   instr_out    out : instruction register
//   instr_valid  out : one-cycle pulse, instr_out is new
//   exec_done    in  : execute finished the current instruction
//   zero_flag    in  : ALU zero flag
//   pc_step      out : one-cycle PC advance pulse
//   branch_en    out : apply imm_out on this pc_step
//   imm_out      out : sign-extended branch offset
//   done         out : processor halted
//   cycle_count  out : active-cycle counter        (FETCH_SEQ_PERF_EN only)
//   instr_count  out : retired-instruction counter (FETCH_SEQ_PERF_EN only)
//
// Configuration macro: FETCH_SEQ_PERF_EN adds the two saturating performance
// counters; without it the counter ports and logic do not exist.
// ============================================================================
module fetch_sequencer
    import fetch_seq_pkg::*;
#(
    parameter int                    INSTR_W    = 9,
    parameter int                    OPCODE_W   = 3,
    parameter logic [OPCODE_W-1:0]   BRANCH_OP  = DEFAULT_BRANCH_OP,
    parameter logic [INSTR_W-1:0]    HALT_INSTR = DEFAULT_HALT_INSTR
`ifdef FETCH_SEQ_PERF_EN
    ,
    parameter int                    CNT_W      = 32
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               imem_req,
    input  logic               imem_ready,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr_out,
    output logic               instr_valid,
    input  logic               exec_done,
    input  logic               zero_flag,
    output logic               pc_step,
    output logic               branch_en,
    output logic [IMM_W-1:0]   imm_out,
    output logic               done
`ifdef FETCH_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0]   cycle_count,
    output logic [CNT_W-1:0]   instr_count
`endif
);

    fseq_state_t        state;
    logic [INSTR_W-1:0] ir;
    logic               taken;
    logic               is_branch;

    assign is_branch = (ir[INSTR_W-1 -: OPCODE_W] == BRANCH_OP);

    // Sequencer FSM. Pulse outputs default low every cycle and are raised on
    // the transition into the state that owns them, so each output is a
    // register and nothing combinational runs from an input to an output.
    // instr_valid is decided while leaving FETCH, from the word being
    // captured, so that it is high exactly during DECODE for non-halt words.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            ir          <= '0;
            taken       <= 1'b0;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
            pc_step     <= 1'b0;
            done        <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            pc_step     <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state    <= ST_FETCH;
                        imem_req <= 1'b1;
                    end
                end

                ST_FETCH: begin
                    if (imem_ready) begin
                        ir          <= imem_rdata;
                        imem_req    <= 1'b0;
                        state       <= ST_DECODE;
                        instr_valid <= (imem_rdata != HALT_INSTR);
                    end
                end

                ST_DECODE: begin
                    if (ir == HALT_INSTR) begin
                        state <= ST_HALTED;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_EXECUTE;
                    end
                end

                // The zero flag only matters in the cycle execute reports
                // completion; earlier values are ignored.
                ST_EXECUTE: begin
                    if (exec_done) begin
                        taken   <= is_branch & zero_flag;
                        pc_step <= 1'b1;
                        state   <= ST_UPDATE;
                    end
                end

                ST_UPDATE: begin
                    state    <= ST_FETCH;
                    imem_req <= 1'b1;
                end

                ST_HALTED: begin
                    done <= 1'b1;
                end

                default: begin
                    state    <= ST_IDLE;
                    imem_req <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // branch_en is qualified by pc_step so it can never appear on its own,
    // even though taken itself is held until the next branch resolves.
    assign branch_en = pc_step & taken;
    assign instr_out = ir;
    assign imm_out   = sext_imm(ir[5:0]);

`ifdef FETCH_SEQ_PERF_EN
    logic cycle_en;
    logic retire_en;

    // Active cycles are everything between start and halt. A halt retires
    // on its DECODE cycle because it never reaches UPDATE.
    assign cycle_en  = (state != ST_IDLE) && (state != ST_HALTED);
    assign retire_en = (state == ST_UPDATE) ||
                       ((state == ST_DECODE) && (ir == HALT_INSTR));

    sat_counter #(.WIDTH(CNT_W)) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .en    (cycle_en),
        .clr   (1'b0),
        .count (cycle_count)
    );

    sat_counter #(.WIDTH(CNT_W)) u_instr_counter (
        .clk   (clk),
        .reset (reset),
        .en    (retire_en),
        .clr   (1'b0),
        .count (instr_count)
    );
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// tb_fetch_sequencer
//
// Purpose: self-checking bench for fetch_sequencer. A table of instruction
// records (word, zero flag, memory/execute stall lengths, expected branch
// qualifier and offset) is walked one instruction at a time, followed by
// hand-written sequences for halt, reset during EXECUTE and, when
// FETCH_SEQ_PERF_EN is defined, the performance counters.
// Inputs change and outputs are sampled on the falling clock edge.
// ============================================================================
module tb_fetch_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       imem_req;
    logic       imem_ready;
    logic [8:0] imem_rdata;
    logic [8:0] instr_out;
    logic       instr_valid;
    logic       exec_done;
    logic       zero_flag;
    logic       pc_step;
    logic       branch_en;
    logic [7:0] imm_out;
    logic       done;
`ifdef FETCH_SEQ_PERF_EN
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
`endif

    int check_count = 0;
    int error_count = 0;

    typedef struct {
        string      name;
        logic [8:0] instr;
        logic       zero;
        int         ready_delay;
        int         exec_delay;
        logic       exp_branch;
        logic [7:0] exp_imm;
    } vec_t;

    localparam int NUM_VECS = 8;
    vec_t vectors [NUM_VECS];

    fetch_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .imem_req    (imem_req),
        .imem_ready  (imem_ready),
        .imem_rdata  (imem_rdata),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .exec_done   (exec_done),
        .zero_flag   (zero_flag),
        .pc_step     (pc_step),
        .branch_en   (branch_en),
        .imm_out     (imm_out),
        .done        (done)
`ifdef FETCH_SEQ_PERF_EN
        ,
        .cycle_count (cycle_count),
        .instr_count (instr_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic rdy, input logic [8:0] rdata,
                                 input logic ed, input logic z);
        start      = s;
        imem_ready = rdy;
        imem_rdata = rdata;
        exec_done  = ed;
        zero_flag  = z;
    endtask

    // Expects to be called at a falling edge with the DUT in FETCH; returns
    // at the falling edge of the following FETCH cycle.
    task automatic runInstr(input vec_t v, input logic [8:0] prev_ir);
        for (int i = 0; i <= v.ready_delay; i++) begin
            checkOutput({v.name, " imem_req"}, 32'(imem_req), 32'd1);
            checkOutput({v.name, " ir_held"}, 32'(instr_out), 32'(prev_ir));
            checkOutput({v.name, " no_step_fetch"}, 32'(pc_step), 32'd0);
            if (i == v.ready_delay) applyStimulus(1'b0, 1'b1, v.instr, 1'b0, 1'b0);
            else                    applyStimulus(1'b0, 1'b0, 9'h0AA, 1'b0, 1'b0);
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        checkOutput({v.name, " instr_valid"}, 32'(instr_valid), 32'd1);
        checkOutput({v.name, " instr_out"}, 32'(instr_out), 32'(v.instr));
        checkOutput({v.name, " req_dropped"}, 32'(imem_req), 32'd0);
        @(negedge clk);
        // The zero flag is driven to the opposite value while execute stalls
        // so that only the value at exec_done may influence the branch.
        for (int i = 0; i <= v.exec_delay; i++) begin
            checkOutput({v.name, " valid_pulse"}, 32'(instr_valid), 32'd0);
            checkOutput({v.name, " no_step_exec"}, 32'(pc_step), 32'd0);
            if (i == v.exec_delay) applyStimulus(1'b0, 1'b0, 9'h000, 1'b1, v.zero);
            else                   applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, ~v.zero);
            @(negedge clk);
        end
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, ~v.zero);
        checkOutput({v.name, " pc_step"}, 32'(pc_step), 32'd1);
        checkOutput({v.name, " branch_en"}, 32'(branch_en), 32'(v.exp_branch));
        checkOutput({v.name, " imm_out"}, 32'(imm_out), 32'(v.exp_imm));
        @(negedge clk);
        checkOutput({v.name, " step_one_cycle"}, 32'(pc_step), 32'd0);
        checkOutput({v.name, " branch_cleared"}, 32'(branch_en), 32'd0);
        checkOutput({v.name, " next_fetch"}, 32'(imem_req), 32'd1);
    endtask

    // Fetches the halt word from FETCH and then hammers start for a few
    // cycles to show HALTED ignores it.
    task automatic runHalt(input logic [8:0] prev_ir);
        checkOutput("halt fetch_req", 32'(imem_req), 32'd1);
        checkOutput("halt ir_held", 32'(instr_out), 32'(prev_ir));
        applyStimulus(1'b0, 1'b1, 9'h1FF, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        checkOutput("halt decode_no_valid", 32'(instr_valid), 32'd0);
        checkOutput("halt decode_not_done", 32'(done), 32'd0);
        checkOutput("halt instr_out", 32'(instr_out), 32'h1FF);
        @(negedge clk);
        checkOutput("halt done", 32'(done), 32'd1);
        checkOutput("halt no_step", 32'(pc_step), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1, 9'h012, 1'b1, 1'b1);
            @(negedge clk);
            checkOutput("halted done_sticky", 32'(done), 32'd1);
            checkOutput("halted no_req", 32'(imem_req), 32'd0);
            checkOutput("halted no_step", 32'(pc_step), 32'd0);
            checkOutput("halted no_valid", 32'(instr_valid), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
    endtask

    task automatic checkAllLow(input string tag);
        checkOutput({tag, " imem_req"}, 32'(imem_req), 32'd0);
        checkOutput({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
        checkOutput({tag, " pc_step"}, 32'(pc_step), 32'd0);
        checkOutput({tag, " branch_en"}, 32'(branch_en), 32'd0);
        checkOutput({tag, " done"}, 32'(done), 32'd0);
        checkOutput({tag, " instr_out"}, 32'(instr_out), 32'd0);
        checkOutput({tag, " imm_out"}, 32'(imm_out), 32'd0);
    endtask

    task automatic pulseStart();
        applyStimulus(1'b1, 1'b0, 9'h000, 1'b0, 1'b0);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
    endtask

    initial begin
        logic [8:0] prev_ir;

        //            name                   instr   z   rdy ex  br    imm
        vectors[0] = '{"nop",                9'h012, 1'b0, 0, 0, 1'b0, 8'h12};
        vectors[1] = '{"beq_taken",          9'h1BE, 1'b1, 0, 0, 1'b1, 8'hFE};
        vectors[2] = '{"beq_not_taken",      9'h1BE, 1'b0, 0, 0, 1'b0, 8'hFE};
        vectors[3] = '{"slow_mem",           9'h012, 1'b0, 3, 0, 1'b0, 8'h12};
        vectors[4] = '{"slow_exec_taken",    9'h185, 1'b1, 0, 2, 1'b1, 8'h05};
        vectors[5] = '{"alu_op_zero",        9'h0A5, 1'b1, 1, 1, 1'b0, 8'hE5};
        vectors[6] = '{"slow_exec_not_tkn",  9'h185, 1'b0, 0, 2, 1'b0, 8'h05};
        vectors[7] = '{"other_op_zero",      9'h1C3, 1'b1, 0, 0, 1'b0, 8'h03};

        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        checkAllLow("reset");
`ifdef FETCH_SEQ_PERF_EN
        checkOutput("reset cycle_count", cycle_count, 32'd0);
        checkOutput("reset instr_count", instr_count, 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle no_req", 32'(imem_req), 32'd0);

        // Main table: one instruction per record, back to back.
        pulseStart();
        prev_ir = 9'h000;
        for (int i = 0; i < NUM_VECS; i++) begin
            runInstr(vectors[i], prev_ir);
            prev_ir = vectors[i].instr;
        end
        runHalt(prev_ir);

        // Reset leaves HALTED.
        reset = 1'b1;
        #1;
        checkOutput("halt_reset done", 32'(done), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset while in EXECUTE: everything clears without waiting for a clock.
        pulseStart();
        applyStimulus(1'b0, 1'b1, 9'h1BE, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b1);
        @(negedge clk);
        checkOutput("exec instr_out", 32'(instr_out), 32'h1BE);
        checkOutput("exec imm_out", 32'(imm_out), 32'hFE);
        #2;
        reset = 1'b1;
        #1;
        checkAllLow("mid_exec_reset");
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b0, 9'h000, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("post_reset idle", 32'(imem_req), 32'd0);

        // Clean restart: three 4-cycle instructions then a halt.
        pulseStart();
        runInstr(vectors[0], 9'h000);
        runInstr(vectors[1], vectors[0].instr);
        runInstr(vectors[2], vectors[1].instr);
        runHalt(vectors[2].instr);
`ifdef FETCH_SEQ_PERF_EN
        checkOutput("perf cycle_count", cycle_count, 32'd14);
        checkOutput("perf instr_count", instr_count, 32'd4);
        repeat (3) @(negedge clk);
        checkOutput("perf cycle_frozen", cycle_count, 32'd14);
        checkOutput("perf instr_frozen", instr_count, 32'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
        $finish;
    end

endmodule
